// File: rtl/circle_engine_if.sv
// Controller / VGA-adapter bundle for circle_engine.
// Carries pix_count only when CIRCLE_ENGINE_PIXCOUNT_EN is defined.
interface circle_engine_if #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
);
   logic                start;
   logic [COLOUR_W-1:0] colour;
   logic [X_W-1:0]      centre_x;
   logic [Y_W-1:0]      centre_y;
   logic [X_W-1:0]      radius;
   logic [7:0]          oct_mask;
   logic                done;
   logic [X_W-1:0]      vga_x;
   logic [Y_W-1:0]      vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                vga_plot;
`ifdef CIRCLE_ENGINE_PIXCOUNT_EN
   logic [15:0]         pix_count;

   modport master (
      output start, colour, centre_x, centre_y, radius, oct_mask,
      input  done, vga_x, vga_y, vga_colour, vga_plot, pix_count
   );
   modport slave (
      input  start, colour, centre_x, centre_y, radius, oct_mask,
      output done, vga_x, vga_y, vga_colour, vga_plot, pix_count
   );
`else
   modport master (
      output start, colour, centre_x, centre_y, radius, oct_mask,
      input  done, vga_x, vga_y, vga_colour, vga_plot
   );
   modport slave (
      input  start, colour, centre_x, centre_y, radius, oct_mask,
      output done, vga_x, vga_y, vga_colour, vga_plot
   );
`endif
endinterface

// File: rtl/circle_engine.sv
// Midpoint circle rasteriser, one octant slot per cycle, clipped.
// Optional plot counter: CIRCLE_ENGINE_PIXCOUNT_EN.
module circle_engine #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input logic            clk,
   input logic            rst_n,
   circle_engine_if.slave bus
);
   localparam int W = X_W + 3;
   localparam logic signed [W-1:0] ZERO = '0;
   localparam logic signed [W-1:0] ONE  = W'(1);
   localparam logic signed [W-1:0] SW   = W'(SCREEN_W);
   localparam logic signed [W-1:0] SH   = W'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, INIT, PLOT, DONE} state_t;

   state_t              state_q;
   logic [2:0]          slot_q;
   logic signed [W-1:0] ox_q, oy_q, crit_q;
   logic signed [W-1:0] cx_q, cy_q;
   logic [7:0]          mask_q;
   logic                done_q, plot_q;
   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      y_q;
   logic [COLOUR_W-1:0] colour_q;

   logic signed [W-1:0] nox, noy, ncrit;
   logic signed [W-1:0] pox, poy, px, py;
   logic [2:0]          ps;
   logic                onscr, pen, fin;

   always_comb begin
      noy   = oy_q + ONE;
      nox   = ox_q;
      ncrit = crit_q + (noy <<< 1) + ONE;
      if (crit_q > ZERO) begin
         nox   = ox_q - ONE;
         ncrit = crit_q + ((noy - nox) <<< 1) + ONE;
      end
   end

   assign fin = (slot_q == 3'd7) && (noy > nox);

   // Outputs are registered, so select the slot that becomes active next.
   always_comb begin
      ps  = slot_q + 3'd1;
      pox = ox_q;
      poy = oy_q;
      if (state_q != PLOT) ps = 3'd0;
      if (state_q == PLOT && slot_q == 3'd7) begin
         pox = nox;
         poy = noy;
      end
   end

   always_comb begin
      px = cx_q + pox;
      py = cy_q + poy;
      unique case (ps)
         3'd0: begin px = cx_q + pox; py = cy_q + poy; end
         3'd1: begin px = cx_q + poy; py = cy_q + pox; end
         3'd2: begin px = cx_q - pox; py = cy_q + poy; end
         3'd3: begin px = cx_q - poy; py = cy_q + pox; end
         3'd4: begin px = cx_q - pox; py = cy_q - poy; end
         3'd5: begin px = cx_q - poy; py = cy_q - pox; end
         3'd6: begin px = cx_q + pox; py = cy_q - poy; end
         3'd7: begin px = cx_q + poy; py = cy_q - pox; end
      endcase
   end

   assign onscr = (px >= ZERO) && (px < SW) &&
                  (py >= ZERO) && (py < SH);
   assign pen   = mask_q[ps] & onscr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         slot_q   <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         crit_q   <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         mask_q   <= '0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               plot_q <= 1'b0;
               x_q    <= '0;
               y_q    <= '0;
               if (bus.start) begin
                  cx_q     <= {3'b000, bus.centre_x};
                  cy_q     <= {{(W-Y_W){1'b0}}, bus.centre_y};
                  mask_q   <= bus.oct_mask;
                  colour_q <= bus.colour;
                  ox_q     <= {3'b000, bus.radius};
                  oy_q     <= ZERO;
                  crit_q   <= ONE - {3'b000, bus.radius};
                  state_q  <= INIT;
               end
            end
            INIT: begin
               plot_q  <= pen;
               x_q     <= pen ? px[X_W-1:0] : '0;
               y_q     <= pen ? py[Y_W-1:0] : '0;
               slot_q  <= 3'd0;
               state_q <= PLOT;
            end
            PLOT: begin
               slot_q <= slot_q + 3'd1;
               if (slot_q == 3'd7) begin
                  ox_q   <= nox;
                  oy_q   <= noy;
                  crit_q <= ncrit;
               end
               if (fin) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  plot_q  <= 1'b0;
                  x_q     <= '0;
                  y_q     <= '0;
               end else begin
                  plot_q <= pen;
                  x_q    <= pen ? px[X_W-1:0] : '0;
                  y_q    <= pen ? py[Y_W-1:0] : '0;
               end
            end
            DONE: begin
               plot_q <= 1'b0;
               x_q    <= '0;
               y_q    <= '0;
               if (!bus.start) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.done       = done_q;
   assign bus.vga_plot   = plot_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = colour_q;

`ifdef CIRCLE_ENGINE_PIXCOUNT_EN
   logic [15:0] pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0;
      end else if (state_q == IDLE && bus.start) begin
         pc_q <= '0;
      end else if (plot_q && pc_q != 16'hFFFF) begin
         pc_q <= pc_q + 16'd1;
      end
   end

   assign bus.pix_count = pc_q;
`endif
endmodule

// File: tb/tb_circle_engine.sv
// Directed bench for circle_engine: vector table plus
// hand sequences for capture, clipping and mid-draw reset.
module tb_circle_engine;
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   circle_engine_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) bus ();

   circle_engine #(
      .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W),
      .SCREEN_W(160), .SCREEN_H(120)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      int cx; int cy; int r; int mask; int col;
      int cyc; int plots; int fx; int fy; int fp;
   } vec_t;

   vec_t tv [6];
   int   checks = 0;
   int   failures = 0;
   int   xs [256];
   int   ys [256];
   int   ps [256];
   int   cyc_r, plots_r, zbad, cbad;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic run_draw(input int cx, input int cy, input int r,
                           input int m, input int col);
      bus.centre_x = X_W'(cx);
      bus.centre_y = Y_W'(cy);
      bus.radius   = X_W'(r);
      bus.oct_mask = 8'(m);
      bus.colour   = C_W'(col);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      chk("init_plot", int'(bus.vga_plot), 0);
      bus.centre_x = '0;
      bus.centre_y = '0;
      bus.radius   = '1;
      bus.oct_mask = 8'h00;
      bus.colour   = ~C_W'(col);
      cyc_r = -1; plots_r = 0; zbad = 0; cbad = 0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            cyc_r = c;
            break;
         end
         if (c <= 256) begin
            xs[c-1] = int'(bus.vga_x);
            ys[c-1] = int'(bus.vga_y);
            ps[c-1] = int'(bus.vga_plot);
         end
         if (bus.vga_plot) plots_r++;
         else if (bus.vga_x != 0 || bus.vga_y != 0) zbad++;
         if (int'(bus.vga_colour) != col) cbad++;
      end
   endtask

   task automatic finish_draw();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
      end
      chk("done_hold", int'(bus.done), 1);
      chk("done_noplot", int'(bus.vga_plot), 0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("done_clear", int'(bus.done), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int far;
      int np, nd;
      tv[0] = '{80, 60, 40, 8'hFF, 5, 233, 232, 120, 60, 1};
      tv[1] = '{10, 10, 0, 8'hFF, 3, 9, 8, 10, 10, 1};
      tv[2] = '{10, 10, 1, 8'hFF, 6, 17, 16, 11, 10, 1};
      tv[3] = '{2, 2, 5, 8'hFF, 7, 33, 14, 7, 2, 1};
      tv[4] = '{80, 60, 40, 8'h01, 1, 233, 29, 120, 60, 1};
      tv[5] = '{158, 118, 3, 8'hFF, 4, 25, 10, 0, 0, 0};

      bus.start = 1'b0;
      bus.centre_x = '0;
      bus.centre_y = '0;
      bus.radius = '0;
      bus.oct_mask = '0;
      bus.colour = '0;
      #1;
      chk("rst_done", int'(bus.done), 0);
      chk("rst_plot", int'(bus.vga_plot), 0);
      chk("rst_x", int'(bus.vga_x), 0);
      chk("rst_y", int'(bus.vga_y), 0);
      chk("rst_colour", int'(bus.vga_colour), 0);
`ifdef CIRCLE_ENGINE_PIXCOUNT_EN
      chk("rst_pix_count", int'(bus.pix_count), 0);
`endif
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_draw(tv[i].cx, tv[i].cy, tv[i].r, tv[i].mask, tv[i].col);
         chk($sformatf("v%0d_cycles", i), cyc_r, tv[i].cyc);
         chk($sformatf("v%0d_plots", i), plots_r, tv[i].plots);
         chk($sformatf("v%0d_first_x", i), xs[0], tv[i].fx);
         chk($sformatf("v%0d_first_y", i), ys[0], tv[i].fy);
         chk($sformatf("v%0d_first_plot", i), ps[0], tv[i].fp);
         chk($sformatf("v%0d_zero_when_off", i), zbad, 0);
         chk($sformatf("v%0d_colour", i), cbad, 0);
`ifdef CIRCLE_ENGINE_PIXCOUNT_EN
         chk($sformatf("v%0d_pix_count", i), int'(bus.pix_count),
             tv[i].plots);
`endif
         finish_draw();
      end

      run_draw(80, 60, 40, 8'hFF, 2);
      chk("basic_s1_x", xs[1], 80);
      chk("basic_s1_y", ys[1], 100);
      chk("basic_s1_plot", ps[1], 1);
      chk("basic_s2_x", xs[2], 40);
      chk("basic_s2_y", ys[2], 60);
      chk("basic_s2_plot", ps[2], 1);
      finish_draw();

      run_draw(10, 10, 1, 8'hFF, 6);
      chk("r1_it2_s0_x", xs[8], 11);
      chk("r1_it2_s0_y", ys[8], 11);
      far = 0;
      for (int k = 0; k < 16; k++)
         if (ps[k] == 1 && (xs[k] > 11 || xs[k] < 9 ||
                            ys[k] > 11 || ys[k] < 9)) far++;
      chk("r1_far_points", far, 0);
      finish_draw();

      run_draw(2, 2, 5, 8'hFF, 7);
      chk("clip_s2_plot", ps[2], 0);
      chk("clip_s2_x", xs[2], 0);
      chk("clip_s2_y", ys[2], 0);
      finish_draw();

      run_draw(80, 60, 5, 8'hFF, 7);
      chk("onscreen_r5_cycles", cyc_r, 33);
      chk("onscreen_r5_plots", plots_r, 32);
      finish_draw();

      bus.centre_x = 8'd80;
      bus.centre_y = 7'd60;
      bus.radius = 8'd40;
      bus.oct_mask = 8'hFF;
      bus.colour = 3'd5;
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
      end
      chk("mid_pre_plot", int'(bus.vga_plot), 1);
      chk("mid_pre_x", int'(bus.vga_x), 79);
      chk("mid_pre_y", int'(bus.vga_y), 100);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_plot", int'(bus.vga_plot), 0);
      chk("mid_rst_x", int'(bus.vga_x), 0);
      chk("mid_rst_y", int'(bus.vga_y), 0);
      chk("mid_rst_done", int'(bus.done), 0);
      chk("mid_rst_colour", int'(bus.vga_colour), 0);
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      np = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.vga_plot) np++;
         if (bus.done) nd++;
      end
      chk("post_rst_plots", np, 0);
      chk("post_rst_done", nd, 0);

      run_draw(10, 10, 0, 8'hFF, 3);
      chk("post_rst_draw_cycles", cyc_r, 9);
      chk("post_rst_draw_plots", plots_r, 8);
      finish_draw();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
